// File: rtl/char_class_decoder.sv
// ============================================================================
// char_class_decoder
// ----------------------------------------------------------------------------
// Purpose: looks up each incoming byte in a 256-entry character-class table.
//   The table holds one NUM_CLASSES-bit class vector per byte value. Each
//   byte produces a per-class match vector two cycles after it is sampled.
//   Start-of-data and end-of-data markers travel with their byte and OR fixed
//   class masks into that byte's result. After reset the controller sweeps
//   the table to zero, one entry per cycle. During that sweep it ignores
//   lookups and configuration writes.
//
// Ports:
//   clk        in   1            clock, all state on its rising edge
//   rst        in   1            asynchronous active-high reset
//   en         in   1            input byte valid
//   i_char     in   8            payload byte
//   sod        in   1            start-of-data marker (qualified by en)
//   eod        in   1            end-of-data marker (qualified by en)
//   o_match    out  NUM_CLASSES  per-class match vector (zero unless o_valid)
//   o_valid    out  1            o_match carries a decoded byte
//   cfg_wr_en  in   1            table write strobe (honoured only when ready)
//   cfg_addr   in   8            table entry to write
//   cfg_data   in   NUM_CLASSES  class bits for that entry
//   cfg_ready  out  1            table initialised; writes and lookups accepted
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module char_class_decoder #(
  parameter int             NUM_CLASSES = 133,
  parameter logic [1023:0]  SOD_MASK    = (1024'(1) << 46) | 1024'(1),
  parameter logic [1023:0]  EOD_MASK    = '0,
  parameter bit             CASE_FOLD   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [7:0]             i_char,
  input  logic                   sod,
  input  logic                   eod,
  output logic [NUM_CLASSES-1:0] o_match,
  output logic                   o_valid,
  input  logic                   cfg_wr_en,
  input  logic [7:0]             cfg_addr,
  input  logic [NUM_CLASSES-1:0] cfg_data,
  output logic                   cfg_ready
);

  // Masks are declared wide so any width of NUM_CLASSES can use them.
  // Bits above the vector width are dropped here.
  localparam logic [NUM_CLASSES-1:0] C_SOD_MASK = SOD_MASK[NUM_CLASSES-1:0];
  localparam logic [NUM_CLASSES-1:0] C_EOD_MASK = EOD_MASK[NUM_CLASSES-1:0];

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state;
  logic [7:0]             clr_cnt;

  // Table write port (shared by the clear sweep and configuration writes).
  logic                   mem_we;
  logic [7:0]             mem_wa;
  logic [NUM_CLASSES-1:0] mem_wd;

  logic [NUM_CLASSES-1:0] mem [256];
  logic [NUM_CLASSES-1:0] rd_data;

  logic [7:0]             lookup_addr;
  logic                   take;

  logic                   s1_valid, s1_sod, s1_eod;
  logic [7:0]             s1_addr;
  logic                   s2_valid, s2_sod, s2_eod;

  // --------------------------------------------------------------------------
  // Controller: CLEAR zeroes entries 0..255, then READY for good.
  // cfg_ready is registered alongside the state so it is exactly "in READY".
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= 8'd0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= 8'(clr_cnt + 8'd1);
          if (clr_cnt == 8'hFF) begin
            state     <= ST_READY;
            cfg_ready <= 1'b1;
          end
        end
        ST_READY: begin
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= ST_CLEAR;
          clr_cnt   <= 8'd0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // The clear sweep owns the write port while it runs.
  // A configuration write issued then is dropped, not queued.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cfg_addr;
    mem_wd = cfg_data;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
      mem_wd = '0;
    end else if (cfg_wr_en) begin
      mem_we = 1'b1;
    end
  end

  // Table: one synchronous read port and one write port.
  // The read samples the array before this edge's write lands (read-first),
  // so a same-entry collision returns the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    rd_data <= mem[s1_addr];
  end

  // Optional ASCII case fold: clearing bit 5 maps 'a'..'z' onto 'A'..'Z'.
  always_comb begin
    lookup_addr = i_char;
    if (CASE_FOLD && (i_char >= 8'h61) && (i_char <= 8'h7A)) begin
      lookup_addr = i_char & 8'hDF;
    end
  end

  assign take = en & cfg_ready;

  // --------------------------------------------------------------------------
  // Pipeline. Stage 1 captures the byte, stage 2 is the table read and
  // stage 3 registers the outputs. The markers ride along with the byte.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sod   <= 1'b0;
      s1_eod   <= 1'b0;
      s1_addr  <= 8'd0;
      s2_valid <= 1'b0;
      s2_sod   <= 1'b0;
      s2_eod   <= 1'b0;
      o_valid  <= 1'b0;
      o_match  <= '0;
    end else begin
      s1_valid <= take;
      s1_sod   <= take & sod;
      s1_eod   <= take & eod;
      s1_addr  <= lookup_addr;

      s2_valid <= s1_valid;
      s2_sod   <= s1_sod;
      s2_eod   <= s1_eod;

      o_valid  <= s2_valid;
      if (s2_valid) begin
        o_match <= rd_data
                 | (s2_sod ? C_SOD_MASK : '0)
                 | (s2_eod ? C_EOD_MASK : '0);
      end else begin
        o_match <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_char_class_decoder.sv
// ============================================================================
// tb_char_class_decoder
// ----------------------------------------------------------------------------
// Purpose: directed self-checking bench for char_class_decoder. It runs two
//   instances on shared inputs: one without case folding (EOD_MASK = bit 2)
//   and one with case folding. Inputs change just after a falling edge, and
//   outputs are sampled at the falling edge, away from the rising clock edge.
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_char_class_decoder;

  localparam int NC = 133;
  localparam logic [NC-1:0] ZERO  = '0;
  localparam logic [NC-1:0] BIT5  = NC'(1) << 5;
  localparam logic [NC-1:0] BIT7  = NC'(1) << 7;
  localparam logic [NC-1:0] BIT9  = NC'(1) << 9;
  localparam logic [NC-1:0] MARKS = (NC'(1) << 0) | (NC'(1) << 2) | (NC'(1) << 46);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [7:0]    i_char = 8'd0;
  logic          sod = 1'b0;
  logic          eod = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [7:0]    cfg_addr = 8'd0;
  logic [NC-1:0] cfg_data = '0;

  logic [NC-1:0] match_a, match_f;
  logic          valid_a, valid_f;
  logic          ready_a, ready_f;

  int checks = 0;
  int errors = 0;
  int cycles;
  int stale;

  always #5 clk = ~clk;

  char_class_decoder #(
    .NUM_CLASSES (NC),
    .EOD_MASK    (1024'(4)),
    .CASE_FOLD   (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_char    (i_char),
    .sod       (sod),
    .eod       (eod),
    .o_match   (match_a),
    .o_valid   (valid_a),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (ready_a)
  );

  char_class_decoder #(
    .NUM_CLASSES (NC),
    .EOD_MASK    (1024'(4)),
    .CASE_FOLD   (1'b1)
  ) dut_f (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_char    (i_char),
    .sod       (sod),
    .eod       (eod),
    .o_match   (match_f),
    .o_valid   (valid_f),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (ready_f)
  );

  task automatic check(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle: the next rising edge samples them.
  // Returns at the following falling edge.
  task automatic drive(input logic e, input logic [7:0] c, input logic s, input logic d);
    en     = e;
    i_char = c;
    sod    = s;
    eod    = d;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [NC-1:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Counts cycles from reset release until cfg_ready rises (bounded).
  // Keeps en high throughout to show that lookups are refused during CLEAR.
  // Optionally issues a late configuration write that must be lost.
  task automatic wait_ready(input bit late_write);
    cycles = 0;
    stale  = 0;
    while (!ready_a && cycles < 400) begin
      en        = 1'b1;
      i_char    = 8'h41;
      cfg_wr_en = late_write && (cycles >= 200) && (cycles < 250);
      cfg_addr  = 8'h41;
      cfg_data  = BIT5;
      @(negedge clk);
      cycles++;
      if (valid_a || valid_f) stale++;
    end
    en        = 1'b0;
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("reset_ready", NC'(ready_a), ZERO);
    check("reset_valid", NC'(valid_a), ZERO);
    check("reset_match", match_a, ZERO);

    // ---------------- CLEAR sweep: 256 cycles, late write lost ----------------
    rst = 1'b0;
    wait_ready(1'b1);
    check("clear_cycles", NC'(cycles), NC'(256));
    check("clear_no_output", NC'(stale), ZERO);
    check("ready_fold_inst", NC'(ready_f), NC'(1));

    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("latency_not_early", NC'(valid_a), ZERO);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("lost_write_valid", NC'(valid_a), NC'(1));
    check("lost_write_match", match_a, ZERO);

    // ---------------- 'A' / 'B' streaming ----------------
    cfg_write(8'h41, BIT5);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("A_valid", NC'(valid_a), NC'(1));
    check("A_match", match_a, BIT5);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("B_valid", NC'(valid_a), NC'(1));
    check("B_match", match_a, ZERO);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_valid", NC'(valid_a), ZERO);
    check("idle_match_zero", match_a, ZERO);

    // ---------------- case folding ----------------
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("nofold_match", match_a, ZERO);
    check("fold_valid", NC'(valid_f), NC'(1));
    check("fold_match", match_f, BIT5);

    // ---------------- sod + eod on one byte ----------------
    drive(1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("marks_match", match_a, MARKS);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("after_marks_valid", NC'(valid_a), NC'(1));
    check("after_marks_match", match_a, ZERO);

    // ---------------- read-first collision on 0x30 ----------------
    cfg_write(8'h30, BIT7);
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    // This cycle's edge reads the first 0x30 and writes the new value.
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'h30;
    cfg_data  = BIT9;
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    cfg_wr_en = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("collide_old", match_a, BIT7);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("collide_new", match_a, BIT9);

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    check("pre_rst_valid", NC'(valid_a), NC'(1));
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", NC'(valid_a), ZERO);
    check("rst_async_match", match_a, ZERO);
    check("rst_async_ready", NC'(ready_a), ZERO);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(1'b0);
    check("reclear_cycles", NC'(cycles), NC'(256));
    check("reclear_no_stale", NC'(stale), ZERO);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("reclear_valid", NC'(valid_a), NC'(1));
    check("reclear_table_zero", match_a, ZERO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
